frame_collect: RTL and testbench
================================

Name: frame_collect

Overview:
Deserializing counterpart of the frame slicer: rebuilds parallel frames from the per-cycle streams produced by the convolutional encoder (coded symbols) and the Viterbi decoder (decoded bits).
Coded symbols (2 or 3 bits per accepted cycle, by code rate) are packed into a 384-bit coded frame. Decoded bits are packed into a 128-bit data frame.
Bit order is the exact inverse of the slicer: highest index first, filling downward. A sliced-then-collected frame therefore round-trips bit-exact.
Sits between the encoder/decoder cores and the frame-level output interface.

Parameters:
DATA_W, 128, data frame width; also the symbols per coded frame.
CODED_W, 384, coded frame width (3*DATA_W).

Ports:
clk  input  1  clock; all logic on posedge.
rst  input  1  synchronous, active-high reset.
en_c  input  1  start/restart pulse for both paths; samples i_code_rate.
i_code_rate  input  1  `CODE_RATE_2 / `CODE_RATE_3 (param_def.sv encodings).
i_enc_valid  input  1  coded symbol present on i_enc_sym this cycle.
i_enc_sym  input  3  coded symbol; rate 1/2 uses [1:0], [2] ignored.
i_dec_valid  input  1  decoded bit present on i_dec_bit this cycle.
i_dec_bit  input  1  decoded bit.
i_ack  input  1  consumer has taken the frame(s); clears done flags.
o_encoder_frame  output  CODED_W  assembled coded frame.
o_decoder_frame  output  DATA_W  assembled data frame.
o_enc_done  output  1  coded frame complete, held until ack.
o_dec_done  output  1  data frame complete, held until ack.
o_ovf  output  1  sticky: a valid arrived while its path was not FILL.

Behaviour:
- Reset (rst=1 at posedge): both frames 0, both done 0, o_ovf 0, both FSMs IDLE, rate register `CODE_RATE_2, pointers 0, counters 0.
- Each path has an independent FSM: IDLE, FILL, DONE. Both paths share en_c and i_ack.
- en_c=1 (any state, highest priority after rst):
  - clear both frames, done flags and o_ovf;
  - latch i_code_rate;
  - load enc pointer 255 (rate 1/2) or 383 (rate 1/3), dec pointer 127, symbol counters 0;
  - both FSMs go to FILL.
  - Valids in the same cycle as en_c are dropped and do not set o_ovf.
- Enc FILL, i_enc_valid=1:
  - rate 1/2: frame[p] <= sym[0], frame[p-1] <= sym[1]; p -= 2.
  - rate 1/3: frame[p] <= sym[0], frame[p-1] <= sym[1], frame[p-2] <= sym[2]; p -= 3.
  - Counter increments. On the DATA_W-th accept, go to DONE and set o_enc_done. Both take effect at the same edge as the final write.
  - Rate 1/2 never writes [383:256]; those bits stay 0.
- Dec FILL, i_dec_valid=1: frame[q] <= i_dec_bit, q -= 1. On the 128th bit, go to DONE and set o_dec_done.
- Latency: a written bit is visible on the frame output the cycle after its valid. Done rises the cycle after the last valid.
- No pointer underflow: the last write uses indices 1,0 (rate 1/2), 2..0 (rate 1/3), or 0 (dec). The FSM leaves FILL before any further write.
- DONE:
  - frame and done are held stable;
  - a valid on that path is dropped and sets o_ovf;
  - i_ack=1 moves that path to IDLE and clears its done; the frame contents are kept.
- IDLE: valid is dropped and sets o_ovf; frame is held.
- i_ack in FILL or IDLE: no effect.
- en_c and i_ack in the same cycle: en_c wins (restart).
- i_code_rate changes outside an en_c cycle: ignored until the next en_c.
- Gaps (valid=0) in FILL: no write, pointer and counter hold. There is no timeout.

Test Plan:
- Reset mid-FILL after 50 enc symbols, rst=1 for one cycle -> all outputs 0, IDLE. Subsequent valids set o_ovf=1.
- en_c with rate 1/2, then 128 consecutive enc symbols 2'b01 -> o_enc_done=1 on the cycle after the 128th. o_encoder_frame[255:0] = {128{2'b10}} (odd index 1, even 0), [383:256]=0.
- en_c with rate 1/3, then 128 symbols 3'b001 with a valid=0 gap every 4th cycle -> done after the 128th accepted symbol. Bits 383,380,...,2 =1, all others 0.
- Dec path: en_c, then 128 bits alternating 1,0 starting with 1 -> o_dec_done=1. o_decoder_frame = {64{2'b10}}.
- After o_enc_done: drive one extra enc valid -> frame unchanged, o_ovf=1. Then i_ack -> o_enc_done=0, frame held. Then en_c -> frames 0, o_ovf=0.
- Round trip: random 128-bit data encoded and sliced into the encoder, output collected at rate 1/3 -> o_encoder_frame equals the frame the slicer consumed, bit-exact.

Source files
------------

// File: rtl/frame_collect.sv
// Rebuilds parallel frames from per-cycle encoder symbols and decoder bits,
// filling from the highest index downward (inverse of the frame slicer).
module frame_collect #(
    parameter int DATA_W  = 128,
    parameter int CODED_W = 384
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_c,
    input  logic               i_code_rate,
    input  logic               i_enc_valid,
    input  logic [2:0]         i_enc_sym,
    input  logic               i_dec_valid,
    input  logic               i_dec_bit,
    input  logic               i_ack,
    output logic [CODED_W-1:0] o_encoder_frame,
    output logic [DATA_W-1:0]  o_decoder_frame,
    output logic               o_enc_done,
    output logic               o_dec_done,
    output logic               o_ovf
);

    localparam logic CODE_RATE_2 = 1'b0;
    localparam logic CODE_RATE_3 = 1'b1;

    localparam int EPW = $clog2(CODED_W);
    localparam int DPW = $clog2(DATA_W);
    localparam int CW  = $clog2(DATA_W) + 1;

    localparam logic [EPW-1:0] ENC_TOP_R2 = EPW'(2 * DATA_W - 1);
    localparam logic [EPW-1:0] ENC_TOP_R3 = EPW'(CODED_W - 1);
    localparam logic [DPW-1:0] DEC_TOP    = DPW'(DATA_W - 1);
    localparam logic [CW-1:0]  LAST_CNT   = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               enc_state_q, enc_state_d;
    state_t               dec_state_q, dec_state_d;
    logic [CODED_W-1:0]   enc_frame_q, enc_frame_d;
    logic [DATA_W-1:0]    dec_frame_q, dec_frame_d;
    logic [EPW-1:0]       enc_ptr_q, enc_ptr_d;
    logic [DPW-1:0]       dec_ptr_q, dec_ptr_d;
    logic [CW-1:0]        enc_cnt_q, enc_cnt_d;
    logic [CW-1:0]        dec_cnt_q, dec_cnt_d;
    logic                 rate_q, rate_d;
    logic                 enc_done_q, enc_done_d;
    logic                 dec_done_q, dec_done_d;
    logic                 ovf_q, ovf_d;
    logic                 enc_acc_s, dec_acc_s;

    assign enc_acc_s = (enc_state_q == ST_FILL) && i_enc_valid;
    assign dec_acc_s = (dec_state_q == ST_FILL) && i_dec_valid;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_state_q <= ST_IDLE;
            dec_state_q <= ST_IDLE;
            enc_frame_q <= '0;
            dec_frame_q <= '0;
            enc_ptr_q   <= '0;
            dec_ptr_q   <= '0;
            enc_cnt_q   <= '0;
            dec_cnt_q   <= '0;
            rate_q      <= CODE_RATE_2;
            enc_done_q  <= 1'b0;
            dec_done_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            enc_state_q <= enc_state_d;
            dec_state_q <= dec_state_d;
            enc_frame_q <= enc_frame_d;
            dec_frame_q <= dec_frame_d;
            enc_ptr_q   <= enc_ptr_d;
            dec_ptr_q   <= dec_ptr_d;
            enc_cnt_q   <= enc_cnt_d;
            dec_cnt_q   <= dec_cnt_d;
            rate_q      <= rate_d;
            enc_done_q  <= enc_done_d;
            dec_done_q  <= dec_done_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state logic for both path FSMs; en_c restarts either path from any state
    always_comb begin
        enc_state_d = enc_state_q;
        dec_state_d = dec_state_q;
        if (en_c) begin
            enc_state_d = ST_FILL;
            dec_state_d = ST_FILL;
        end else begin
            case (enc_state_q)
                ST_IDLE: enc_state_d = ST_IDLE;
                ST_FILL: begin
                    if (enc_acc_s && (enc_cnt_q == LAST_CNT)) begin
                        enc_state_d = ST_DONE;
                    end else begin
                        enc_state_d = ST_FILL;
                    end
                end
                ST_DONE: begin
                    if (i_ack) begin
                        enc_state_d = ST_IDLE;
                    end else begin
                        enc_state_d = ST_DONE;
                    end
                end
                default: enc_state_d = ST_IDLE;
            endcase
            case (dec_state_q)
                ST_IDLE: dec_state_d = ST_IDLE;
                ST_FILL: begin
                    if (dec_acc_s && (dec_cnt_q == LAST_CNT)) begin
                        dec_state_d = ST_DONE;
                    end else begin
                        dec_state_d = ST_FILL;
                    end
                end
                ST_DONE: begin
                    if (i_ack) begin
                        dec_state_d = ST_IDLE;
                    end else begin
                        dec_state_d = ST_DONE;
                    end
                end
                default: dec_state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: frame writes, pointers, counters, flags
    always_comb begin
        enc_frame_d = enc_frame_q;
        dec_frame_d = dec_frame_q;
        enc_ptr_d   = enc_ptr_q;
        dec_ptr_d   = dec_ptr_q;
        enc_cnt_d   = enc_cnt_q;
        dec_cnt_d   = dec_cnt_q;
        rate_d      = rate_q;
        ovf_d       = ovf_q;
        enc_done_d  = (enc_state_d == ST_DONE);
        dec_done_d  = (dec_state_d == ST_DONE);
        if (en_c) begin
            enc_frame_d = '0;
            dec_frame_d = '0;
            rate_d      = i_code_rate;
            enc_ptr_d   = (i_code_rate == CODE_RATE_3) ? ENC_TOP_R3 : ENC_TOP_R2;
            dec_ptr_d   = DEC_TOP;
            enc_cnt_d   = '0;
            dec_cnt_d   = '0;
            ovf_d       = 1'b0;
        end else begin
            if (enc_acc_s) begin
                enc_frame_d[enc_ptr_q]                 = i_enc_sym[0];
                enc_frame_d[enc_ptr_q - EPW'(1)]       = i_enc_sym[1];
                if (rate_q == CODE_RATE_3) begin
                    enc_frame_d[enc_ptr_q - EPW'(2)]   = i_enc_sym[2];
                    enc_ptr_d                          = enc_ptr_q - EPW'(3);
                end else begin
                    enc_ptr_d                          = enc_ptr_q - EPW'(2);
                end
                enc_cnt_d = enc_cnt_q + CW'(1);
            end else if (i_enc_valid) begin
                ovf_d = 1'b1;
            end else begin
                enc_cnt_d = enc_cnt_q;
            end
            if (dec_acc_s) begin
                dec_frame_d[dec_ptr_q] = i_dec_bit;
                dec_ptr_d              = dec_ptr_q - DPW'(1);
                dec_cnt_d              = dec_cnt_q + CW'(1);
            end else if (i_dec_valid) begin
                ovf_d = 1'b1;
            end else begin
                dec_cnt_d = dec_cnt_q;
            end
        end
    end

    assign o_encoder_frame = enc_frame_q;
    assign o_decoder_frame = dec_frame_q;
    assign o_enc_done      = enc_done_q;
    assign o_dec_done      = dec_done_q;
    assign o_ovf           = ovf_q;

endmodule

// File: tb/tb_frame_collect.sv
// Directed bench for frame_collect: reset, both code rates, gaps, overflow,
// ack/restart handling and a slicer-style round trip at rate 1/3.
module tb_frame_collect;

    logic         clk = 1'b0;
    logic         rst, en_c, i_code_rate, i_enc_valid, i_dec_valid, i_dec_bit, i_ack;
    logic [2:0]   i_enc_sym;
    logic [383:0] o_encoder_frame;
    logic [127:0] o_decoder_frame;
    logic         o_enc_done, o_dec_done, o_ovf;

    int checks   = 0;
    int failures = 0;

    logic [383:0] exp_enc;
    logic [127:0] exp_dec;
    logic [383:0] rnd;

    frame_collect dut (
        .clk             (clk),
        .rst             (rst),
        .en_c            (en_c),
        .i_code_rate     (i_code_rate),
        .i_enc_valid     (i_enc_valid),
        .i_enc_sym       (i_enc_sym),
        .i_dec_valid     (i_dec_valid),
        .i_dec_bit       (i_dec_bit),
        .i_ack           (i_ack),
        .o_encoder_frame (o_encoder_frame),
        .o_decoder_frame (o_decoder_frame),
        .o_enc_done      (o_enc_done),
        .o_dec_done      (o_dec_done),
        .o_ovf           (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en_c = 1'b0; i_code_rate = 1'b0; i_enc_valid = 1'b0;
        i_enc_sym = 3'd0; i_dec_valid = 1'b0; i_dec_bit = 1'b0; i_ack = 1'b0;
        tick();
        rst = 1'b0;
        chk("reset_enc_frame", o_encoder_frame, 384'd0);
        chk("reset_dec_frame", {256'd0, o_decoder_frame}, 384'd0);
        chk("reset_flags", {381'd0, o_enc_done, o_dec_done, o_ovf}, 384'd0);

        // reset mid-FILL after 50 symbols
        en_c = 1'b1; i_code_rate = 1'b0; tick(); en_c = 1'b0;
        i_enc_valid = 1'b1; i_enc_sym = 3'b011;
        for (int k = 0; k < 50; k++) tick();
        i_enc_valid = 1'b0;
        exp_enc = '0;
        for (int k = 0; k < 100; k++) exp_enc[255 - k] = 1'b1;
        chk("partial_fill_r2", o_encoder_frame, exp_enc);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midfill_reset_frame", o_encoder_frame, 384'd0);
        chk("midfill_reset_flags", {381'd0, o_enc_done, o_dec_done, o_ovf}, 384'd0);
        i_enc_valid = 1'b1; i_enc_sym = 3'b111; tick(); i_enc_valid = 1'b0;
        chk("idle_valid_ovf", {383'd0, o_ovf}, 384'd1);
        chk("idle_valid_frame_held", o_encoder_frame, 384'd0);

        // rate 1/2, sym[2] set but must be ignored; valid with en_c dropped
        en_c = 1'b1; i_code_rate = 1'b0; i_enc_valid = 1'b1; i_enc_sym = 3'b101; tick();
        en_c = 1'b0;
        chk("enc_restart_clears", {o_encoder_frame[383:1], o_ovf}, 384'd0);
        for (int k = 0; k < 127; k++) tick();
        chk("r2_not_done_at_127", {383'd0, o_enc_done}, 384'd0);
        tick(); i_enc_valid = 1'b0;
        chk("r2_done", {383'd0, o_enc_done}, 384'd1);
        exp_enc = {128'd0, {128{2'b10}}};
        chk("r2_frame", o_encoder_frame, exp_enc);
        chk("r2_dec_not_done", {383'd0, o_dec_done}, 384'd0);
        i_enc_valid = 1'b1; i_enc_sym = 3'b010; tick(); i_enc_valid = 1'b0;
        chk("done_extra_frame", o_encoder_frame, exp_enc);
        chk("done_extra_ovf", {383'd0, o_ovf}, 384'd1);
        tick();
        chk("done_held", {383'd0, o_enc_done}, 384'd1);
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        chk("ack_clears_done", {383'd0, o_enc_done}, 384'd0);
        chk("ack_frame_held", o_encoder_frame, exp_enc);

        // rate 1/3 with gaps; en_c and ack together -> restart
        en_c = 1'b1; i_ack = 1'b1; i_code_rate = 1'b1; tick();
        en_c = 1'b0; i_ack = 1'b0; i_code_rate = 1'b0;
        chk("restart_frame", o_encoder_frame, 384'd0);
        chk("restart_flags", {381'd0, o_enc_done, o_dec_done, o_ovf}, 384'd0);
        i_enc_sym = 3'b001;
        begin
            int acc = 0;
            int cyc = 0;
            while (acc < 127) begin
                i_enc_valid = (cyc % 4 == 3) ? 1'b0 : 1'b1;
                if (i_enc_valid) acc++;
                cyc++;
                tick();
            end
        end
        i_enc_valid = 1'b0; tick();
        chk("r3_gap_not_done", {383'd0, o_enc_done}, 384'd0);
        i_enc_valid = 1'b1; tick(); i_enc_valid = 1'b0;
        chk("r3_done", {383'd0, o_enc_done}, 384'd1);
        exp_enc = '0;
        for (int k = 0; k < 128; k++) exp_enc[383 - 3 * k] = 1'b1;
        chk("r3_frame", o_encoder_frame, exp_enc);
        chk("r3_no_ovf", {383'd0, o_ovf}, 384'd0);

        // dec path alternating 1,0
        en_c = 1'b1; tick(); en_c = 1'b0;
        i_dec_valid = 1'b1;
        for (int k = 0; k < 127; k++) begin
            i_dec_bit = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick();
        end
        chk("dec_not_done_127", {383'd0, o_dec_done}, 384'd0);
        i_dec_bit = 1'b0; tick(); i_dec_valid = 1'b0;
        chk("dec_done", {383'd0, o_dec_done}, 384'd1);
        exp_dec = {64{2'b10}};
        chk("dec_frame", {256'd0, o_decoder_frame}, {256'd0, exp_dec});
        i_ack = 1'b1; tick(); i_ack = 1'b0;
        chk("dec_ack", {383'd0, o_dec_done}, 384'd0);
        chk("dec_ack_frame_held", {256'd0, o_decoder_frame}, {256'd0, exp_dec});

        // round trip: slice a random frame highest-first, collect at rate 1/3
        for (int w = 0; w < 12; w++) rnd[w * 32 +: 32] = $urandom;
        en_c = 1'b1; i_code_rate = 1'b1; tick(); en_c = 1'b0;
        i_enc_valid = 1'b1; i_dec_valid = 1'b1;
        for (int k = 0; k < 128; k++) begin
            i_enc_sym = {rnd[381 - 3 * k], rnd[382 - 3 * k], rnd[383 - 3 * k]};
            i_dec_bit = rnd[127 - k];
            tick();
        end
        i_enc_valid = 1'b0; i_dec_valid = 1'b0;
        chk("rt_enc_frame", o_encoder_frame, rnd);
        chk("rt_dec_frame", {256'd0, o_decoder_frame}, {256'd0, rnd[127:0]});
        chk("rt_flags", {381'd0, o_enc_done, o_dec_done, o_ovf}, 384'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
